// File: rtl/iob_native_split_pkg.sv
// Shared definitions for the native-to-IOb split bridge: FSM encoding,
// default parameter values and the strobe-width helper.
package iob_native_split_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_N_SLAVES    = 4;
  localparam int DEF_SEL_W       = 2;
  localparam int DEF_INSTR_SLAVE = 0;
  localparam int DEF_TIMEOUT_W   = 8;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_native_timeout.sv
// Bus timeout counter: counts enabled cycles since the last clear and flags the
// cycle that completes the (2^W-1)-th one. W=0 ties the expiry off.
module iob_native_timeout #(
  parameter int W = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic cke_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  if (W == 0) begin : g_off
    logic unused_tie;
    assign unused_tie = &{1'b0, clk_i, rst_n_i, cke_i, clr_i, en_i};
    assign expire_o   = 1'b0;
  end else begin : g_cnt
    // count_q holds cycles already completed, so expiry is one short of all-ones.
    localparam logic [W-1:0] LAST = ~W'(1);
    logic [W-1:0] count_q;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        count_q <= '0;
      end else if (cke_i) begin
        if (clr_i)     count_q <= '0;
        else if (en_i) count_q <= count_q + W'(1);
      end
    end

    assign expire_o = en_i && (count_q == LAST);
  end

endmodule

// File: rtl/iob_native_split.sv
// Steers a held-until-ready native CPU request onto one of N_SLAVES IOb ports,
// with instruction-fetch steering, bus timeout and discard of late read data.
module iob_native_split
  import iob_native_split_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int N_SLAVES    = DEF_N_SLAVES,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int INSTR_SLAVE = DEF_INSTR_SLAVE,
  parameter int TIMEOUT_W   = DEF_TIMEOUT_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 cke_i,
  input  logic                                 valid_i,
  input  logic                                 instr_i,
  input  logic [ADDR_W-1:0]                    addr_i,
  input  logic [DATA_W-1:0]                    wdata_i,
  input  logic [strb_w(DATA_W)-1:0]            wstrb_i,
  output logic [DATA_W-1:0]                    rdata_o,
  output logic                                 ready_o,
  output logic                                 err_o,
  output logic [N_SLAVES-1:0]                  avalid_o,
  output logic [N_SLAVES*ADDR_W-1:0]           address_o,
  output logic [N_SLAVES*DATA_W-1:0]           wdata_o,
  output logic [N_SLAVES*strb_w(DATA_W)-1:0]   wstrb_o,
  input  logic [N_SLAVES*DATA_W-1:0]           rdata_i,
  input  logic [N_SLAVES-1:0]                  rvalid_i,
  input  logic [N_SLAVES-1:0]                  ready_i
);

  localparam int STRB_W = strb_w(DATA_W);

  state_t              state_q;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q, rdata_sel;
  logic [STRB_W-1:0]   wstrb_q;
  logic                err_q;
  logic [N_SLAVES-1:0] drop_q, sel_oh;
  logic                sel_ok, ready_sel, rvalid_sel, drop_sel;
  logic                tmo_clr, tmo_en, tmo_expire;

  assign sel_d  = instr_i ? SEL_W'(INSTR_SLAVE) : addr_i[ADDR_W-1 -: SEL_W];
  assign sel_ok = int'(sel_d) < N_SLAVES;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    sel_oh    = '0;
    rdata_sel = '0;
    for (int p = 0; p < N_SLAVES; p++) begin
      sel_oh[p] = (int'(sel_q) == p);
      if (sel_oh[p]) rdata_sel = rdata_i[p*DATA_W +: DATA_W];
    end
  end

  assign ready_sel  = |(ready_i & sel_oh);
  assign rvalid_sel = |(rvalid_i & sel_oh);
  assign drop_sel   = |(drop_q & sel_oh);

  assign tmo_clr = (state_q == IDLE) && valid_i && sel_ok;
  assign tmo_en  = (state_q == REQ) || (state_q == WAIT_R);

  iob_native_timeout #(.W(TIMEOUT_W)) u_timeout (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .cke_i    (cke_i),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      drop_q  <= '0;
    end else if (cke_i) begin
      // Any response arriving on a port with a pending drop consumes that drop.
      drop_q <= drop_q & ~rvalid_i;
      unique case (state_q)
        IDLE: if (valid_i) begin
          sel_q   <= sel_d;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          wstrb_q <= wstrb_i;
          rdata_q <= '0;
          err_q   <= !sel_ok;
          state_q <= sel_ok ? REQ : ACK;
        end
        REQ: if (ready_sel) begin
          err_q   <= 1'b0;
          state_q <= (|wstrb_q) ? ACK : WAIT_R;
        end else if (tmo_expire) begin
          err_q   <= 1'b1;
          state_q <= ACK;
        end
        WAIT_R: if (rvalid_sel && !drop_sel) begin
          rdata_q <= rdata_sel;
          err_q   <= 1'b0;
          state_q <= ACK;
        end else if (tmo_expire) begin
          drop_q  <= (drop_q & ~rvalid_i) | sel_oh;
          err_q   <= 1'b1;
          state_q <= ACK;
        end
        ACK: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    avalid_o  = '0;
    address_o = '0;
    wdata_o   = '0;
    wstrb_o   = '0;
    if (state_q == REQ) begin
      for (int p = 0; p < N_SLAVES; p++) begin
        if (sel_oh[p]) begin
          avalid_o[p]                      = 1'b1;
          address_o[p*ADDR_W +: ADDR_W]    = addr_q;
          wdata_o[p*DATA_W +: DATA_W]      = wdata_q;
          wstrb_o[p*STRB_W +: STRB_W]      = wstrb_q;
        end
      end
    end
  end

  assign ready_o = (state_q == ACK);
  assign err_o   = ready_o & err_q;
  assign rdata_o = ready_o ? rdata_q : '0;

endmodule

// File: doc/iob_native_split.md
Name: iob_native_split

Overview:
- Parametrised bridge from a CPU native memory port (valid/ready, request held until ready) to N_SLAVES independent IOb ports (avalid/ready/rvalid).
- Generalises the single instruction/data steering used today:
  - slave select by address MSBs, with instruction fetches forced to a fixed slave;
  - explicit write-acknowledge handling;
  - bus timeout with error flag;
  - discard of late read responses.
- Sits between the CPU core wrapper and the interconnect/peripheral bus.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- N_SLAVES, 4, number of IOb ports (1..16).
- SEL_W, 2, address MSBs used for slave select; must satisfy 2^SEL_W >= N_SLAVES.
- INSTR_SLAVE, 0, port that always receives requests with instr_i=1.
- TIMEOUT_W, 8, timeout counter width; 0 disables timeout.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- cke_i  in  1  clock enable; all state holds when low
- valid_i  in  1  native request valid; held until ready_o
- instr_i  in  1  request is an instruction fetch
- addr_i  in  ADDR_W  native address
- wdata_i  in  DATA_W  write data
- wstrb_i  in  DATA_W/8  write strobes; 0 means read
- rdata_o  out  DATA_W  read data, valid while ready_o=1
- ready_o  out  1  one-cycle completion pulse
- err_o  out  1  completion carries error; valid with ready_o
- avalid_o  out  N_SLAVES  per-port IOb address valid
- address_o  out  N_SLAVES*ADDR_W  per-port address, flattened, port 0 in LSBs
- wdata_o  out  N_SLAVES*DATA_W  per-port write data
- wstrb_o  out  N_SLAVES*DATA_W/8  per-port write strobes
- rdata_i  in  N_SLAVES*DATA_W  per-port read data
- rvalid_i  in  N_SLAVES  per-port read-data valid
- ready_i  in  N_SLAVES  per-port request accept

Behaviour:
- Reset (rst_n_i=0 at clk edge): FSM to IDLE; counter, drop flags, latched request and rdata_o cleared. All outputs are 0 in reset and in IDLE.
- FSM states: IDLE, REQ, WAIT_R, ACK.
- IDLE:
  - On valid_i=1, latch addr, wdata, wstrb and sel. sel = INSTR_SLAVE if instr_i=1, else addr_i[ADDR_W-1 -: SEL_W].
  - If sel >= N_SLAVES, go to ACK with err=1 and rdata=0; no IOb activity.
  - Otherwise go to REQ.
- REQ:
  - avalid_o[sel]=1. address_o, wdata_o and wstrb_o on port sel come from the latches; all other ports are 0.
  - On ready_i[sel]=1: a write (wstrb!=0) goes to ACK with err=0; a read goes to WAIT_R.
  - Timeout: avalid_o is withdrawn, go to ACK with err=1, rdata=0.
- WAIT_R:
  - avalid_o is 0.
  - On rvalid_i[sel]=1 with drop[sel]=0: capture rdata_i slice into rdata_o, go to ACK with err=0.
  - On rvalid_i[sel]=1 with drop[sel]=1: clear drop[sel] and stay.
  - Timeout: set drop[sel]=1, go to ACK with err=1, rdata_o=0.
- ACK: ready_o=1 for exactly one cycle, err_o as latched; then IDLE.
- Latency without wait states:
  - Write: valid_i at cycle 0, avalid at cycle 1, ready_o at cycle 2.
  - Read with rvalid one cycle after accept: ready_o at cycle 3.
- Back-to-back: valid_i still high in the cycle after ACK is a new request.
- Timeout counter:
  - Counts cycles spent in REQ+WAIT_R; cleared on entering REQ.
  - Expires when it equals 2^TIMEOUT_W-1.
  - If ready_i or a valid rvalid_i arrives in the same cycle as expiry, the bus response wins.
- Drop flags are per port. A drop flag only discards the first rvalid from that port; a second timeout on a port whose flag is already set leaves it set (only one late response is absorbed).
- rvalid_i on a port not currently selected is ignored, but it does clear that port's drop flag if set.
- cke_i=0 freezes FSM, counter and flags; combinational outputs still follow the frozen state.
- Reset mid-transaction: avalid_o drops in the next cycle and no ready_o is issued. Drop flags are cleared, so late responses after reset are the system's responsibility.

Decomposition:
- Shared header iob_native_split_conf.vh holds:
  - FSM state encoding (2-bit: IDLE=0, REQ=1, WAIT_R=2, ACK=3);
  - the default parameter values;
  - the helper for DATA_W/8.
- One sub-module, iob_native_timeout: a TIMEOUT_W-bit counter with clear, enable and expire outputs. It is tied off when TIMEOUT_W=0.

Test Plan:
- Write to addr 0x4000_0010, wstrb=0xF, ready_i[1]=1 immediately -> avalid_o[1] high 1 cycle at cycle 1, ready_o=1 and err_o=0 at cycle 2; no other port active.
- Read with instr_i=1 at addr 0xC000_0000, rvalid_i[0] with 0xDEADBEEF 2 cycles after accept -> ready_o with rdata_o=0xDEADBEEF; port 3 untouched.
- N_SLAVES=3, read at addr 0xC000_0000 -> ready_o with err_o=1 and rdata_o=0 at cycle 1; no avalid_o.
- TIMEOUT_W=4, read to port 2 never answered -> ready_o with err_o=1 after 15 cycles in REQ+WAIT_R. A later rvalid_i[2] with 0x1234 is dropped; the next read to port 2 returns its own 0x5678.
- Read in WAIT_R, rst_n_i low 1 cycle -> avalid_o=0, no ready_o, FSM in IDLE. A new request completes normally.
- cke_i low 5 cycles during REQ with ready_i held -> state and outputs frozen; completion resumes after cke_i returns.
